conv1x1_relu_engine: RTL

Parametrised 1x1 convolution engine generalising the fire-module expand-1x1 layers. Any number of layers sharing one datapath, selected at start. One input channel per beat, CHOUT parallel MAC lanes, bias add, ReLU and saturating fixed-point requantisation. Sits between the squeeze-layer output RAM and the expand output RAM. External per-layer weight ROMs and bias tables are addressed and muxed through `layer_q`.

---
 rtl/conv1x1_pkg.sv | 39 +++
 rtl/conv1x1_relu_engine_if.sv | 38 +++
 rtl/conv1x1_mac_lane.sv | 37 +++
 rtl/conv1x1_relu_engine.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/conv1x1_pkg.sv
// Shared types and helpers for the 1x1 convolution + ReLU engine.
package conv1x1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of a select/index field that must be at least one bit wide.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Out-of-range layer requests fall back to the highest implemented layer.
  function automatic int clamp_layer(input int sel, input int num_layers);
    return (sel >= num_layers) ? num_layers - 1 : sel;
  endfunction

  // ReLU, arithmetic shift into the output Q-format, then clip to the largest
  // positive value representable in 'width' signed bits. Operates on a
  // sign-extended 64-bit copy so one function serves every accumulator width.
  function automatic logic signed [63:0] quant_relu(input logic signed [63:0] s,
                                                    input int frac_shift,
                                                    input int width);
    logic signed [63:0] q;
    logic signed [63:0] max_pos;
    max_pos = (64'sd1 <<< (width - 1)) - 64'sd1;
    q = s >>> frac_shift;
    if (s < 64'sd0) begin
      q = '0;
    end else if (q > max_pos) begin
      q = max_pos;
    end
    return q;
  endfunction

endpackage

// File: rtl/conv1x1_relu_engine_if.sv
// Handshake, weight/bias and output bus between the engine and its surroundings.
interface conv1x1_relu_engine_if
  import conv1x1_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int CHIN       = 32,
  parameter int CHOUT      = 128,
  parameter int NUM_LAYERS = 2
);
  localparam int LW = sel_width(NUM_LAYERS);
  localparam int CW = sel_width(CHIN);

  logic                              start;
  logic [LW-1:0]                     layer_sel;
  logic                              ifm_valid;
  logic                              ifm_ready;
  logic [WIDTH-1:0]                  ifm;
  logic [LW-1:0]                     layer_q;
  logic [CW-1:0]                     weight_addr;
  logic [CHOUT-1:0][WIDTH-1:0]       kernels;
  logic [CHOUT-1:0][ACC_WIDTH-1:0]   bias;
  logic [CHOUT-1:0][WIDTH-1:0]       ofm;
  logic                              ofm_valid;
  logic                              busy;
  logic                              done;

  modport slave (
    input  start, layer_sel, ifm_valid, ifm, kernels, bias,
    output ifm_ready, layer_q, weight_addr, ofm, ofm_valid, busy, done
  );

  modport master (
    output start, layer_sel, ifm_valid, ifm, kernels, bias,
    input  ifm_ready, layer_q, weight_addr, ofm, ofm_valid, busy, done
  );

endinterface

// File: rtl/conv1x1_mac_lane.sv
// One signed multiply-accumulate lane. 'sum' is the value the accumulator will
// take on an enabled cycle, exposed so the quantiser can use it without waiting
// a further cycle for the accumulator register.
module conv1x1_mac_lane
  import conv1x1_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        first,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [ACC_WIDTH-1:0] sum
);

  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc;

  assign prod     = a * b;
  assign prod_ext = ACC_WIDTH'(prod);
  // The first channel of a pixel reloads instead of adding, so no clear bubble.
  assign sum      = first ? prod_ext : acc + prod_ext;

  // Accumulator register, advancing only on valid stage-1 data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/conv1x1_relu_engine.sv
// 1x1 convolution engine: one input channel per beat, CHOUT parallel MAC lanes,
// bias add, ReLU and saturating requantisation, any of NUM_LAYERS layers.
module conv1x1_relu_engine
  import conv1x1_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int CHIN       = 32,
  parameter int CHOUT      = 128,
  parameter int WOUT       = 32,
  parameter int NUM_LAYERS = 2,
  parameter int FRAC_SHIFT = 14
) (
  input logic                   clk,
  input logic                   rst,
  conv1x1_relu_engine_if.slave  bus
);

  localparam int LW   = sel_width(NUM_LAYERS);
  localparam int CW   = sel_width(CHIN);
  localparam int NPIX = WOUT * WOUT;
  localparam int PW   = $clog2(NPIX + 1);

  state_t state;
  state_t next_state;

  logic [CW-1:0] ch_cnt;
  logic [PW-1:0] in_pix;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] layer_q_r;
  logic          beat;
  logic          last_ch;
  logic          last_pix;
  logic          start_ok;

  logic                            s1_valid;
  logic                            s1_first;
  logic                            s1_last;
  logic signed [WIDTH-1:0]         s1_ifm;
  logic [CHOUT-1:0][WIDTH-1:0]     s1_kern;
  logic [CHOUT-1:0][ACC_WIDTH-1:0] lane_sum;
  logic signed [ACC_WIDTH-1:0]     sum_bias [CHOUT];
  logic [CHOUT-1:0][WIDTH-1:0]     quant_vec;
  logic [CHOUT-1:0][WIDTH-1:0]     ofm_r;
  logic                            ofm_valid_r;

  logic busy_c;
  logic ready_c;
  logic done_c;

  assign beat     = (state == ST_RUN) && bus.ifm_valid;
  assign last_ch  = (ch_cnt == CW'(CHIN - 1));
  assign last_pix = (in_pix == PW'(NPIX - 1));
  assign start_ok = (state == ST_IDLE) && bus.start;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; DRAIN ends on the output pulse of the final pixel.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (bus.start) next_state = ST_RUN;
      ST_RUN:   if (beat && last_ch && last_pix) next_state = ST_DRAIN;
      ST_DRAIN: if (ofm_valid_r && (pix_cnt == PW'(NPIX))) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_c  = (state != ST_IDLE);
    ready_c = (state == ST_RUN);
    done_c  = (state == ST_DONE);
  end

  // Layer latch plus input-side channel and pixel counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer_q_r <= '0;
      ch_cnt    <= '0;
      in_pix    <= '0;
    end else if (start_ok) begin
      layer_q_r <= LW'(clamp_layer(int'(bus.layer_sel), NUM_LAYERS));
      ch_cnt    <= '0;
      in_pix    <= '0;
    end else if (beat) begin
      ch_cnt <= last_ch ? '0 : ch_cnt + CW'(1);
      if (last_ch) begin
        in_pix <= in_pix + PW'(1);
      end
    end
  end

  // Stage 1: capture the sample and its kernel column with pixel-boundary flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_ifm   <= '0;
      s1_kern  <= '0;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_first <= (ch_cnt == '0);
        s1_last  <= last_ch;
        s1_ifm   <= bus.ifm;
        s1_kern  <= bus.kernels;
      end
    end
  end

  // Stage 2: one MAC lane per output channel.
  for (genvar i = 0; i < CHOUT; i++) begin : g_lane
    conv1x1_mac_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (s1_valid),
      .first (s1_first),
      .a     (s1_ifm),
      .b     (s1_kern[i]),
      .sum   (lane_sum[i])
    );
  end

  // Bias add (wrapping) and requantisation of the completed lane sums.
  always_comb begin
    quant_vec = '0;
    for (int i = 0; i < CHOUT; i++) begin
      sum_bias[i]  = $signed(lane_sum[i]) + $signed(bus.bias[i]);
      quant_vec[i] = WIDTH'(quant_relu(64'(sum_bias[i]), FRAC_SHIFT, WIDTH));
    end
  end

  // Stage 3: register the output pixel, pulse valid and count finished pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ofm_r       <= '0;
      ofm_valid_r <= 1'b0;
      pix_cnt     <= '0;
    end else begin
      ofm_valid_r <= s1_valid && s1_last;
      if (s1_valid && s1_last) begin
        ofm_r   <= quant_vec;
        pix_cnt <= pix_cnt + PW'(1);
      end else if (start_ok) begin
        pix_cnt <= '0;
      end
    end
  end

  assign bus.ifm_ready   = ready_c;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.layer_q     = layer_q_r;
  assign bus.weight_addr = ch_cnt;
  assign bus.ofm         = ofm_r;
  assign bus.ofm_valid   = ofm_valid_r;

endmodule
